// File: rtl/risc16b_mem_pkg.sv
// Shared constants for the risc16b memory/IO responder: IO page and register map.
package risc16b_mem_pkg;

    localparam logic [7:0]  IO_PAGE    = 8'h7f;

    localparam logic [15:0] ADDR_LED   = 16'h7f00;
    localparam logic [15:0] ADDR_CNTLO = 16'h7f02;
    localparam logic [15:0] ADDR_CNTHI = 16'h7f04;
    localparam logic [15:0] ADDR_SW    = 16'h7f06;
    localparam logic [15:0] ADDR_HALT  = 16'h7f08;

    // Registers are word-aligned, so the decode index is address bits [7:1].
    localparam logic [6:0]  IDX_LED    = ADDR_LED[7:1];
    localparam logic [6:0]  IDX_CNTLO  = ADDR_CNTLO[7:1];
    localparam logic [6:0]  IDX_CNTHI  = ADDR_CNTHI[7:1];
    localparam logic [6:0]  IDX_SW     = ADDR_SW[7:1];
    localparam logic [6:0]  IDX_HALT   = ADDR_HALT[7:1];

    function automatic logic is_io_page(input logic [7:0] page);
        return (page == IO_PAGE);
    endfunction

endpackage

// File: rtl/risc16b_io_regs.sv
// IO page peripherals: LED register, free-running counter with high-half
// shadow, synchronised switch input and sticky halt flag.
module risc16b_io_regs
    import risc16b_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sel_i,
    input  logic [6:0]  idx_i,
    input  logic        oe_i,
    input  logic [1:0]  we_i,
    input  logic [15:0] wdata_i,
    input  logic [15:0] sw_i,
    output logic [15:0] rdata_o,
    output logic [15:0] led_o,
    output logic        halt_o
);

    logic [15:0] led_q, led_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] shadow_q, shadow_d;
    logic        halt_q, halt_d;
    logic [15:0] sync1_q, sync2_q;

    logic        led_hit_s, cntlo_hit_s, halt_hit_s, wr_s;

    always_comb begin
        led_hit_s   = sel_i && (idx_i == IDX_LED);
        cntlo_hit_s = sel_i && (idx_i == IDX_CNTLO);
        halt_hit_s  = sel_i && (idx_i == IDX_HALT);
        wr_s        = (we_i != 2'b00);
    end

    // Lane 0 carries the high byte, matching the big-endian RAM layout.
    always_comb begin
        led_d = led_q;
        if (led_hit_s && we_i[0]) begin
            led_d[15:8] = wdata_i[15:8];
        end else begin
            led_d[15:8] = led_q[15:8];
        end
        if (led_hit_s && we_i[1]) begin
            led_d[7:0] = wdata_i[7:0];
        end else begin
            led_d[7:0] = led_q[7:0];
        end
    end

    // A clear write beats the increment; the shadow captures the pre-increment value.
    always_comb begin
        cnt_d    = cnt_q + 32'd1;
        shadow_d = shadow_q;
        halt_d   = halt_q;
        if (cntlo_hit_s && wr_s) begin
            cnt_d = 32'd0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
        if (cntlo_hit_s && oe_i) begin
            shadow_d = cnt_q[31:16];
        end else begin
            shadow_d = shadow_q;
        end
        if (halt_hit_s && wr_s && (wdata_i != 16'h0000)) begin
            halt_d = 1'b1;
        end else begin
            halt_d = halt_q;
        end
    end

    always_comb begin
        rdata_o = 16'h0000;
        if (sel_i) begin
            case (idx_i)
                IDX_LED:   rdata_o = led_q;
                IDX_CNTLO: rdata_o = cnt_q[15:0];
                IDX_CNTHI: rdata_o = shadow_q;
                IDX_SW:    rdata_o = sync2_q;
                IDX_HALT:  rdata_o = {15'b0, halt_q};
                default:   rdata_o = 16'h0000;
            endcase
        end else begin
            rdata_o = 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q    <= 16'h0000;
            cnt_q    <= 32'd0;
            shadow_q <= 16'h0000;
            halt_q   <= 1'b0;
            sync1_q  <= 16'h0000;
            sync2_q  <= 16'h0000;
        end else begin
            led_q    <= led_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            halt_q   <= halt_d;
            sync1_q  <= sw_i;
            sync2_q  <= sync1_q;
        end
    end

    assign led_o  = led_q;
    assign halt_o = halt_q;

endmodule

// File: rtl/risc16b_mem_io.sv
// Memory/IO responder for the risc16b core: unified big-endian byte RAM with
// combinational fetch/data reads, byte-lane writes and the 0x7fxx IO page.
module risc16b_mem_io
    import risc16b_mem_pkg::*;
#(
    parameter int    MEM_ADDR_W = 16,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_addr,
    input  logic        i_oe,
    output logic [15:0] i_din,
    input  logic [15:0] d_addr,
    input  logic        d_oe,
    output logic [15:0] d_din,
    input  logic [15:0] d_dout,
    input  logic [1:0]  d_we,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        halt
);

    localparam int MEM_BYTES = 2 ** MEM_ADDR_W;
    localparam logic [MEM_ADDR_W-1:0] EVEN_MASK = {{(MEM_ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [MEM_ADDR_W-1:0] ODD_BIT   = {{(MEM_ADDR_W-1){1'b0}}, 1'b1};

    logic [7:0] mem [MEM_BYTES];

    logic                  i_io_s, d_io_s;
    logic [MEM_ADDR_W-1:0] i_hi_s, i_lo_s, d_hi_s, d_lo_s;
    logic [15:0]           i_word_s, d_word_s, io_rdata_s;

    always_comb begin
        i_io_s   = is_io_page(i_addr[15:8]);
        d_io_s   = is_io_page(d_addr[15:8]);
        i_hi_s   = i_addr[MEM_ADDR_W-1:0] & EVEN_MASK;
        i_lo_s   = i_addr[MEM_ADDR_W-1:0] | ODD_BIT;
        d_hi_s   = d_addr[MEM_ADDR_W-1:0] & EVEN_MASK;
        d_lo_s   = d_addr[MEM_ADDR_W-1:0] | ODD_BIT;
        i_word_s = {mem[i_hi_s], mem[i_lo_s]};
        d_word_s = {mem[d_hi_s], mem[d_lo_s]};
    end

    always_comb begin
        i_din = 16'h0000;
        if (i_oe && !i_io_s) begin
            i_din = i_word_s;
        end else begin
            i_din = 16'h0000;
        end
    end

    always_comb begin
        d_din = 16'h0000;
        if (!d_oe) begin
            d_din = 16'h0000;
        end else if (d_io_s) begin
            d_din = io_rdata_s;
        end else begin
            d_din = d_word_s;
        end
    end

    // RAM is deliberately outside reset: a write during rst still commits.
    always_ff @(posedge clk) begin
        if (d_we[0] && !d_io_s) begin
            mem[d_hi_s] <= d_dout[15:8];
        end
        if (d_we[1] && !d_io_s) begin
            mem[d_lo_s] <= d_dout[7:0];
        end
    end

    risc16b_io_regs u_io_regs (
        .clk     (clk),
        .rst     (rst),
        .sel_i   (d_io_s),
        .idx_i   (d_addr[7:1]),
        .oe_i    (d_oe),
        .we_i    (d_we),
        .wdata_i (d_dout),
        .sw_i    (sw),
        .rdata_o (io_rdata_s),
        .led_o   (led),
        .halt_o  (halt)
    );

endmodule

// File: tb/tb_risc16b_mem_io.sv
// Scoreboard bench for risc16b_mem_io: directed scenarios plus random traffic
// checked against a byte-map / cycle-count reference model.
module tb_risc16b_mem_io;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] i_addr, i_din, d_addr, d_din, d_dout, sw, led;
    logic        i_oe, d_oe, halt;
    logic [1:0]  d_we;

    risc16b_mem_io #(.MEM_ADDR_W(16), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_oe(i_oe), .i_din(i_din),
        .d_addr(d_addr), .d_oe(d_oe), .d_din(d_din),
        .d_dout(d_dout), .d_we(d_we),
        .sw(sw), .led(led), .halt(halt)
    );

    typedef struct packed {
        bit        chk_i;
        bit [15:0] exp_i;
        bit        chk_d;
        bit [15:0] exp_d;
        bit [15:0] exp_led;
        bit        exp_halt;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model state
    bit [7:0]  mem_m [int];
    bit [15:0] led_m    = 16'h0000;
    bit [31:0] cnt_m    = 32'd0;
    bit [15:0] shadow_m = 16'h0000;
    bit        halt_m   = 1'b0;
    bit [15:0] sw_hist[$];

    function automatic bit known(input bit [15:0] a);
        return mem_m.exists(int'(a & 16'hfffe)) && mem_m.exists(int'(a | 16'h0001));
    endfunction

    function automatic bit [15:0] ram_word(input bit [15:0] a);
        return {mem_m[int'(a & 16'hfffe)], mem_m[int'(a | 16'h0001)]};
    endfunction

    function automatic bit [15:0] io_read(input bit [15:0] a);
        case (a & 16'h00fe)
            16'h0000: return led_m;
            16'h0002: return cnt_m[15:0];
            16'h0004: return shadow_m;
            16'h0006: return sw_hist[0];
            16'h0008: return {15'b0, halt_m};
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, predict, let the edge happen, then advance the model.
    task automatic cycle(input bit [15:0] ia, input bit ioe, input bit [15:0] da, input bit doe,
                         input bit [15:0] dout, input bit [1:0] we, input bit r, input string tag);
        exp_t      e;
        bit        io;
        bit [15:0] off;
        rst = r; i_addr = ia; i_oe = ioe; d_addr = da; d_oe = doe; d_dout = dout; d_we = we;
        e.exp_led  = led_m;
        e.exp_halt = halt_m;
        e.chk_i = 1'b1; e.exp_i = 16'h0000;
        if (!ioe || ia[15:8] == 8'h7f) e.exp_i = 16'h0000;
        else if (known(ia))            e.exp_i = ram_word(ia);
        else                           e.chk_i = 1'b0;
        e.chk_d = 1'b1; e.exp_d = 16'h0000;
        if (!doe)                      e.exp_d = 16'h0000;
        else if (da[15:8] == 8'h7f)    e.exp_d = io_read(da);
        else if (known(da))            e.exp_d = ram_word(da);
        else                           e.chk_d = 1'b0;
        sb.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        io  = (da[15:8] == 8'h7f);
        off = da & 16'h00fe;
        if (!io) begin
            if (we[0]) mem_m[int'(da & 16'hfffe)] = dout[15:8];
            if (we[1]) mem_m[int'(da | 16'h0001)] = dout[7:0];
        end
        if (r) begin
            led_m = 16'h0000; cnt_m = 32'd0; shadow_m = 16'h0000; halt_m = 1'b0;
            sw_hist.delete(); sw_hist.push_back(16'h0000); sw_hist.push_back(16'h0000);
        end else begin
            if (io && off == 16'h0002 && doe) shadow_m = cnt_m[31:16];
            if (io && off == 16'h0002 && we != 2'b00) cnt_m = 32'd0;
            else cnt_m = cnt_m + 32'd1;
            if (io && off == 16'h0000 && we[0]) led_m[15:8] = dout[15:8];
            if (io && off == 16'h0000 && we[1]) led_m[7:0]  = dout[7:0];
            if (io && off == 16'h0008 && we != 2'b00 && dout != 16'h0000) halt_m = 1'b1;
            sw_hist.push_back(sw);
            void'(sw_hist.pop_front());
        end
        #1;
    endtask

    task automatic idle(input string tag);
        cycle(16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b00, 1'b0, tag);
    endtask

    task automatic rd(input bit [15:0] a, input string tag);
        cycle(16'h0000, 1'b0, a, 1'b1, 16'h0000, 2'b00, 1'b0, tag);
    endtask

    task automatic wr(input bit [15:0] a, input bit [15:0] v, input bit [1:0] we, input string tag);
        cycle(16'h0000, 1'b0, a, 1'b0, v, we, 1'b0, tag);
    endtask

    function automatic bit [15:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 16'hc000 | 16'($urandom_range(0, 15));
            1:       return 16'($urandom_range(0, 15));
            2:       return 16'h7f00 | 16'($urandom_range(0, 15));
            default: return 16'($urandom());
        endcase
    endfunction

    // Monitor: one expected record per cycle, compared on the falling edge.
    initial begin : monitor
        exp_t  e;
        string t;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                t = tag_q.pop_front();
                if (e.chk_i) check16({t, "/i_din"}, i_din, e.exp_i);
                if (e.chk_d) check16({t, "/d_din"}, d_din, e.exp_d);
                check16({t, "/led"}, led, e.exp_led);
                check16({t, "/halt"}, {15'b0, halt}, {15'b0, e.exp_halt});
            end
        end
    end

    initial begin : stimulus
        int guard;
        rst = 1'b1; i_addr = 16'h0000; i_oe = 1'b0; d_addr = 16'h0000; d_oe = 1'b0;
        d_dout = 16'h0000; d_we = 2'b00; sw = 16'h0000;
        sw_hist.push_back(16'h0000); sw_hist.push_back(16'h0000);
        repeat (2) @(posedge clk);
        #1;

        rd(16'h7f00, "rst_led");
        rd(16'h7f02, "rst_cntlo");
        rd(16'h7f04, "rst_cnthi");
        rd(16'h7f06, "rst_sw");
        rd(16'h7f08, "rst_halt");
        rd(16'h7f0e, "unmapped");

        wr(16'h0000, 16'h1234, 2'b11, "t1_wr");
        cycle(16'h0001, 1'b1, 16'h0000, 1'b0, 16'h0000, 2'b00, 1'b0, "t1_fetch");
        cycle(16'h0001, 1'b0, 16'h0001, 1'b1, 16'h0000, 2'b00, 1'b0, "t1_fetch_off");

        wr(16'hc000, 16'h0000, 2'b11, "t2_init");
        cycle(16'hc001, 1'b1, 16'hc000, 1'b1, 16'habcd, 2'b01, 1'b0, "t2_lane0");
        cycle(16'hc000, 1'b1, 16'hc001, 1'b1, 16'habcd, 2'b10, 1'b0, "t2_lane1");
        cycle(16'hc000, 1'b1, 16'hc000, 1'b1, 16'h0000, 2'b00, 1'b0, "t2_full");

        cycle(16'h7f00, 1'b1, 16'h7f00, 1'b1, 16'h00ff, 2'b11, 1'b0, "t3_led_wr");
        rd(16'h7f00, "t3_led_rd");
        wr(16'h7f01, 16'ha5a5, 2'b01, "t3_led_lane0");
        rd(16'h7f01, "t3_led_rd2");
        cycle(16'h0000, 1'b0, 16'h7f00, 1'b0, 16'h1234, 2'b11, 1'b1, "t3_rst_io");
        cycle(16'h0000, 1'b0, 16'hc002, 1'b0, 16'hbeef, 2'b11, 1'b1, "t3_rst_ram");
        cycle(16'hc003, 1'b1, 16'hc002, 1'b1, 16'h0000, 2'b00, 1'b0, "t3_ram_rd");

        sw = 16'h5a5a;
        for (int i = 0; i < 4; i++) rd(16'h7f06, "t5_sw");
        sw = 16'h0f0f;
        for (int i = 0; i < 3; i++) rd(16'h7f07, "t5_sw2");

        wr(16'h7f08, 16'h0000, 2'b11, "t6_halt0");
        rd(16'h7f08, "t6_rd0");
        wr(16'h7f08, 16'h0001, 2'b10, "t6_halt1");
        rd(16'h7f08, "t6_rd1");
        wr(16'h7f08, 16'h0000, 2'b11, "t6_halt0b");
        rd(16'h7f08, "t6_rd2");
        cycle(16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b00, 1'b1, "t6_rst");
        rd(16'h7f08, "t6_rd3");

        // Counter: walk to the low-half rollover and check the shadow coherence.
        guard = 0;
        while (cnt_m != 32'h0000ffff && guard < 70000) begin
            idle("t4_wait");
            guard++;
        end
        rd(16'h7f02, "t4_lo_ffff");
        rd(16'h7f04, "t4_hi_shadow");
        rd(16'h7f02, "t4_lo_next");
        rd(16'h7f04, "t4_hi_one");
        cycle(16'h0000, 1'b0, 16'h7f02, 1'b1, 16'h0000, 2'b11, 1'b0, "t4_clr");
        rd(16'h7f02, "t4_after_clr");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) sw = 16'($urandom());
            cycle(pick_addr(), 1'($urandom()), pick_addr(), 1'($urandom()),
                  ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom()),
                  2'($urandom()), ($urandom_range(0, 63) == 0), "rand");
        end

        repeat (3) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
